// File: rtl/cpu_defs.sv
// cpu_defs: shared constants for the fetch stage and control decoder.
//   - opcode values for the 9-bit instruction set
//   - bit positions of the format/opcode/sign fields in an instruction word
//   - fetch sequencer state type
package cpu_defs;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_LOAD   = 4'b0001;
   localparam logic [3:0] OP_STORE  = 4'b0010;
   localparam logic [3:0] OP_JUMP   = 4'b0011;
   localparam logic [3:0] OP_BRANCH = 4'b0100;
   localparam logic [3:0] OP_EPAR   = 4'b0101;
   localparam logic [3:0] OP_CP     = 4'b0111;
   localparam logic [3:0] OP_SHIFT  = 4'b1010;
   localparam logic [3:0] OP_HALT   = 4'b1011;

   localparam int unsigned FMT_BIT  = 8;
   localparam int unsigned OPC_HI   = 7;
   localparam int unsigned OPC_LO   = 4;
   localparam int unsigned SIGN_BIT = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      HALTED = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk     in   rising-edge clock
//   clear   in   synchronous clear, wins over enable
//   enable  in   count by one this edge (unless already saturated)
//   value   out  CNT_W current count
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] value
);

   always_ff @(posedge clk) begin
      if (clear) begin
         value <= '0;
      end else if (enable && (value != '1)) begin
         value <= value + CNT_W'(1);
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter, instruction-word split and run sequencer.
//   clk, reset          clock; synchronous active-high reset
//   start               begin/restart execution from START_ADDR (ignored in RUN)
//   imem_addr/imem_data asynchronous instruction-ROM interface
//   format/opcode/sign  decoder fields, instr raw word for immediates
//   branch/br_taken/br_offset, jump/jump_target, halt
//                       next-PC controls from decoder and datapath
//   pc                  current program counter
//   running/done        in RUN / in HALTED
//   cycle_count         saturating count of RUN cycles
module instruction_fetch
   import cpu_defs::*;
#(
   parameter int unsigned PC_W       = 10,
   parameter int unsigned INSTR_W    = 9,
   parameter int unsigned OFF_W      = 6,
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic               format,
   output logic [3:0]         opcode,
   output logic               sign,
   output logic [INSTR_W-1:0] instr,
   input  logic               branch,
   input  logic               br_taken,
   input  logic [OFF_W-1:0]   br_offset,
   input  logic               jump,
   input  logic [PC_W-1:0]    jump_target,
   input  logic               halt,
   output logic [PC_W-1:0]    pc,
   output logic               running,
   output logic               done,
   output logic [CNT_W-1:0]   cycle_count
);

   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] br_sext;
   logic            load;

   // Signed cast sign-extends the offset; the add then wraps modulo 2^PC_W.
   assign br_sext = PC_W'($signed(br_offset));

   // A start accepted outside RUN reloads the PC and clears the counter.
   assign load = start && (state_q != RUN);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= START_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state / next PC
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         RUN: begin
            if (halt) begin
               state_d = HALTED;
            end else if (jump) begin
               pc_d = jump_target;
            end else if (branch && br_taken) begin
               pc_d = pc_q + br_sext;
            end else begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         default: begin
            if (start) begin
               state_d = RUN;
               pc_d    = START_PC;
            end
         end
      endcase
   end

   // Outputs
   always_comb begin
      running   = (state_q == RUN);
      done      = (state_q == HALTED);
      pc        = pc_q;
      imem_addr = pc_q;
      format    = imem_data[FMT_BIT];
      opcode    = imem_data[OPC_HI:OPC_LO];
      sign      = imem_data[SIGN_BIT];
      instr     = imem_data;
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .clear (reset || load),
      .enable(state_q == RUN),
      .value (cycle_count)
   );

endmodule
